// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared state encoding and line-address helpers for mem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int LINE_OFFSET_BITS = 4;

    // Callers truncate the result to their index width, which gives the modulo.
    function automatic logic [63:0] line_index(input logic [63:0] addr);
        return addr >> LINE_OFFSET_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// Module      : mem_array
// Description : Line-wide backing store, one synchronous write port and one
//               combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array
    import mem_pkg::*;
#(
    parameter int MEM_LINES     = 1024,
    parameter int MEM_BUS_WIDTH = 128,
    parameter int IDX_W         = $clog2(MEM_LINES)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [IDX_W-1:0]         waddr,
    input  logic [MEM_BUS_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]         raddr,
    output logic [MEM_BUS_WIDTH-1:0] rdata
);

    logic [MEM_BUS_WIDTH-1:0] r_mem [MEM_LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Main-memory controller arbitrating iCache refills and dCache
//               refills/write-backs with a fixed access latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_BUS_WIDTH = 128,
    parameter int MEM_LINES     = 1024,
    parameter int MEM_LATENCY   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ic_req,
    input  logic [ADDR_WIDTH-1:0]    ic_addr,
    output logic                     ic_ack,
    output logic [MEM_BUS_WIDTH-1:0] ic_rdata,
    input  logic                     dc_req,
    input  logic                     dc_we,
    input  logic [ADDR_WIDTH-1:0]    dc_addr,
    input  logic [MEM_BUS_WIDTH-1:0] dc_wdata,
    output logic                     dc_ack,
    output logic [MEM_BUS_WIDTH-1:0] dc_rdata,
    output logic                     busy
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MEM_LATENCY - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic                     r_we;
    logic [MEM_BUS_WIDTH-1:0] r_wdata;
    logic                     w_accept_d;
    logic                     w_accept_i;
    logic                     w_done;
    logic                     w_mem_we;
    logic [IDX_W-1:0]         w_idx;
    logic [MEM_BUS_WIDTH-1:0] w_rd_line;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept_d  = 1'b0;
        w_accept_i  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                // dCache wins ties.
                if (dc_req) begin
                    w_accept_d  = 1'b1;
                    w_state_nxt = BUSY_D;
                    w_cnt_nxt   = c_cnt_load;
                end else if (ic_req) begin
                    w_accept_i  = 1'b1;
                    w_state_nxt = BUSY_I;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            BUSY_I, BUSY_D: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            ic_ack   <= 1'b0;
            dc_ack   <= 1'b0;
            ic_rdata <= '0;
            dc_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept_d) begin
                r_addr  <= dc_addr;
                r_we    <= dc_we;
                r_wdata <= dc_wdata;
            end else if (w_accept_i) begin
                r_addr <= ic_addr;
                r_we   <= 1'b0;
            end
            ic_ack <= w_done && (r_state == BUSY_I);
            dc_ack <= w_done && (r_state == BUSY_D);
            if (w_done && (r_state == BUSY_I)) begin
                ic_rdata <= w_rd_line;
            end
            if (w_done && (r_state == BUSY_D) && !r_we) begin
                dc_rdata <= w_rd_line;
            end
        end
    end

    // Gate with reset so an access aborted on its final cycle never writes.
    assign w_mem_we = w_done && (r_state == BUSY_D) && r_we && !reset;
    assign w_idx    = IDX_W'(line_index(64'(r_addr)));
    assign busy     = (r_state != IDLE);

    mem_array #(
        .MEM_LINES     (MEM_LINES),
        .MEM_BUS_WIDTH (MEM_BUS_WIDTH),
        .IDX_W         (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (w_idx),
        .wdata (r_wdata),
        .raddr (w_idx),
        .rdata (w_rd_line)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl against a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

    localparam int LAT  = 5;
    localparam int LAT1 = 1;
    localparam logic [127:0] c_pat  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] c_pat2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, ic_ack, dc_req, dc_we, dc_ack, busy;
    logic [31:0]  ic_addr, dc_addr;
    logic [127:0] ic_rdata, dc_wdata, dc_rdata;

    logic         ic_req_1, ic_ack_1, dc_req_1, dc_we_1, dc_ack_1, busy_1;
    logic [31:0]  ic_addr_1, dc_addr_1;
    logic [127:0] ic_rdata_1, dc_wdata_1, dc_rdata_1;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] ref_mem [int];

    always #5 clk = ~clk;

    mem_ctrl #(
        .ADDR_WIDTH(32), .MEM_BUS_WIDTH(128), .MEM_LINES(1024), .MEM_LATENCY(LAT)
    ) u_dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ack(dc_ack), .dc_rdata(dc_rdata), .busy(busy)
    );

    mem_ctrl #(
        .ADDR_WIDTH(32), .MEM_BUS_WIDTH(128), .MEM_LINES(1024), .MEM_LATENCY(LAT1)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .ic_req(ic_req_1), .ic_addr(ic_addr_1), .ic_ack(ic_ack_1), .ic_rdata(ic_rdata_1),
        .dc_req(dc_req_1), .dc_we(dc_we_1), .dc_addr(dc_addr_1), .dc_wdata(dc_wdata_1),
        .dc_ack(dc_ack_1), .dc_rdata(dc_rdata_1), .busy(busy_1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_rd(input logic [31:0] a);
        int idx;
        idx = int'((a >> 4) % 1024);
        return ref_mem.exists(idx) ? ref_mem[idx] : '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = iCache refill, 1 = dCache refill, 2 = dCache write-back.
    task automatic xact(input int kind, input logic [31:0] addr, input logic [127:0] wd,
                        input bit scramble, input logic [31:0] alt, input bit early);
        logic [127:0] exp_d, prev_ic, prev_dc;
        int n;
        bit seen;
        exp_d   = ref_rd(addr);
        prev_ic = ic_rdata;
        prev_dc = dc_rdata;
        if (kind == 0) begin
            ic_req  = 1'b1;
            ic_addr = addr;
        end else begin
            dc_req   = 1'b1;
            dc_we    = (kind == 2);
            dc_addr  = addr;
            dc_wdata = wd;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (n == 1) begin
                check("busy_after_accept", busy, 1);
                if (scramble) begin
                    ic_addr  = alt;
                    dc_addr  = alt;
                    dc_wdata = ~wd;
                    if (kind != 0) dc_we = ~dc_we;
                end
                if (early) begin
                    ic_req = 1'b0;
                    dc_req = 1'b0;
                end
            end
            seen = (kind == 0) ? ic_ack : dc_ack;
        end
        check("ack_latency", n, LAT + 1);
        if (kind == 0) begin
            check("ic_rdata", ic_rdata, exp_d);
            check("dc_rdata_hold", dc_rdata, prev_dc);
        end else if (kind == 1) begin
            check("dc_rdata", dc_rdata, exp_d);
            check("ic_rdata_hold", ic_rdata, prev_ic);
        end else begin
            check("dc_rdata_wb_hold", dc_rdata, prev_dc);
            ref_mem[int'((addr >> 4) % 1024)] = wd;
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        step();
        check("ack_pulse", {ic_ack, dc_ack}, 0);
        check("idle_after_done", busy, 0);
    endtask

    always @(posedge clk) begin
        #2;
        if (ic_ack || dc_ack) check("ack_exclusive", ic_ack & dc_ack, 0);
    end

    initial begin
        int t1, t2, td, ti, n;
        logic [31:0] a;
        reset = 1'b1;
        {ic_req, dc_req, dc_we, ic_req_1, dc_req_1, dc_we_1} = '0;
        {ic_addr, dc_addr, ic_addr_1, dc_addr_1} = '0;
        dc_wdata = '0;
        dc_wdata_1 = '0;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_flags", {ic_ack, dc_ack, busy, ic_ack_1, dc_ack_1, busy_1}, 0);
            check("idle_rdata", ic_rdata | dc_rdata | ic_rdata_1 | dc_rdata_1, 0);
        end

        // Reset during a write-back of line 3 must leave the line untouched.
        xact(2, 32'h30, '0, 0, 0, 0);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h30; dc_wdata = c_pat2;
        step();
        check("abort_busy", busy, 1);
        step();
        reset = 1'b1;
        dc_req = 1'b0;
        step();
        check("reset_flags", {ic_ack, dc_ack, busy}, 0);
        check("reset_dc_rdata", dc_rdata, 0);
        check("reset_ic_rdata", ic_rdata, 0);
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            check("no_ack_after_abort", {dc_ack, busy}, 0);
        end
        xact(1, 32'h30, '0, 0, 0, 0);
        check("abort_no_write", dc_rdata, 0);

        // Write-back then refill of the same line from a different offset.
        xact(2, 32'h40, c_pat, 0, 0, 0);
        xact(1, 32'h4C, '0, 0, 0, 0);
        check("wb_then_refill", dc_rdata, c_pat);

        // Address change after accept is ignored.
        xact(0, 32'h40, '0, 1, 32'h80, 0);
        check("addr_change_ignored", ic_rdata, c_pat);

        // Simultaneous requests: dCache first.
        xact(2, 32'h50, c_pat2, 0, 0, 0);
        ic_req = 1'b1; ic_addr = 32'h40;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h50;
        td = 0; ti = 0; n = 0;
        while ((td == 0 || ti == 0) && n < 60) begin
            step();
            n++;
            if (dc_ack && td == 0) begin
                td = n;
                dc_req = 1'b0;
                check("simul_dc_rdata", dc_rdata, c_pat2);
            end
            if (ic_ack && ti == 0) begin
                ti = n;
                ic_req = 1'b0;
                check("simul_ic_rdata", ic_rdata, c_pat);
            end
        end
        check("simul_dc_time", td, LAT + 1);
        check("simul_ic_time", ti, 2 * LAT + 3);
        ic_req = 1'b0; dc_req = 1'b0;
        step();

        // Held request: back-to-back acks spaced by latency + 2.
        ic_req = 1'b1; ic_addr = 32'h40;
        ic_req_1 = 1'b1; ic_addr_1 = 32'h10;
        t1 = 0; t2 = 0; td = 0; ti = 0; n = 0;
        while ((t2 == 0 || ti == 0) && n < 60) begin
            step();
            n++;
            if (ic_ack) begin
                if (t1 == 0) t1 = n; else if (t2 == 0) begin t2 = n; ic_req = 1'b0; end
            end
            if (ic_ack_1) begin
                if (td == 0) td = n; else if (ti == 0) begin ti = n; ic_req_1 = 1'b0; end
            end
        end
        check("held_first_ack", t1, LAT + 1);
        check("held_spacing", t2 - t1, LAT + 2);
        check("lat1_first_ack", td, LAT1 + 1);
        check("lat1_spacing", ti - td, LAT1 + 2);
        ic_req = 1'b0; ic_req_1 = 1'b0;
        step();

        // Index wrap: line 1024 aliases line 0.
        xact(2, 32'h4000, c_pat2, 0, 0, 0);
        xact(0, 32'h0, '0, 0, 0, 0);
        check("index_wrap", ic_rdata, c_pat2);

        // Randomized traffic over lines 0..15 with aliased upper address bits.
        for (int l = 0; l < 16; l++) begin
            xact(2, 32'(l) << 4, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 4)
                | 32'($urandom_range(0, 15));
            xact(int'($urandom_range(0, 2)), a, {$urandom, $urandom, $urandom, $urandom},
                 bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Main-memory controller that services line refills from the instruction cache and line refills/write-backs from the data cache over the 128-bit memory bus. It sits directly downstream of the datapath's `iCache` and `dCache` miss ports. It arbitrates the two requesters, models a fixed access latency, and holds the backing store. One request is in flight at a time; data-cache requests win ties.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte-address width of requests.
- `MEM_BUS_WIDTH`, 128: line width; one line per transfer.
- `MEM_LINES`, 1024: backing-store depth in lines (power of two).
- `MEM_LATENCY`, 5: cycles from accept to ack; legal range ≥ 1.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `ic_req`  in  1: iCache refill request, level, held until `ic_ack`.
- `ic_addr`  in  ADDR_WIDTH: iCache miss byte address.
- `ic_ack`  out  1: one-cycle completion pulse.
- `ic_rdata`  out  MEM_BUS_WIDTH: refill line, valid while `ic_ack`=1, held until next `ic_ack`.
- `dc_req`  in  1: dCache request, level, held until `dc_ack`.
- `dc_we`  in  1: 1 = write-back, 0 = refill.
- `dc_addr`  in  ADDR_WIDTH: dCache byte address.
- `dc_wdata`  in  MEM_BUS_WIDTH: write-back line.
- `dc_ack`  out  1: one-cycle completion pulse.
- `dc_rdata`  out  MEM_BUS_WIDTH: refill line, valid while `dc_ack`=1.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Line index = `addr[ADDR_WIDTH-1:4]` modulo `MEM_LINES`; `addr[3:0]` ignored.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: if `dc_req` → latch `dc_addr`, `dc_we`, `dc_wdata`, go BUSY_D. Else if `ic_req` → latch `ic_addr`, go BUSY_I. Else stay.
- BUSY_x: down-counter loaded with MEM_LATENCY-1 on accept.
  - Counter ≠ 0 → decrement.
  - Counter = 0 → complete and go DONE.
    - Refill: read array at the latched index, register the result into `x_rdata`, pulse `x_ack`.
    - Write-back: write the latched line into the array. `dc_rdata` is unchanged.
- DONE: one cycle; the ack is high here. Next state is IDLE unconditionally. This gives the requester its cycle to see the ack and drop `req`.
- Input changes on addr, `we` or `wdata` after accept are ignored.
- A req dropped before its ack does not abort the access; the ack is still issued.
- Counter width: $clog2(MEM_LATENCY+1); no wrap possible.
- Reset outputs:
  - `ic_ack`=0, `dc_ack`=0, `busy`=0.
  - `ic_rdata`=0, `dc_rdata`=0.
  - state IDLE, counter 0.
- Reset mid-access aborts it: no array write, no ack.
- Array contents are not reset; they are zero-initialised at time 0 for simulation.

## Timing
- Request sampled at edge k.
  - `busy` high from cycle k+1.
  - Ack and rdata visible in the cycle after edge k+MEM_LATENCY.
  - Back in IDLE after edge k+MEM_LATENCY+1.
- With MEM_LATENCY=1, the ack appears in the cycle after edge k+1.
- Minimum spacing between accepts is MEM_LATENCY+2 edges.
- A request held continuously after its ack is taken as a new request at the next IDLE.
- Simultaneous `ic_req`/`dc_req` in IDLE: dCache is served first. iCache is accepted at the following IDLE if still requested.
- A write-back followed by a refill of the same line returns the new data; the write lands before DONE.
- `ic_ack` and `dc_ack` are never high together.

## Structure
- Package `mem_pkg` holds:
  - the state encoding (2-bit enum IDLE/BUSY_I/BUSY_D/DONE);
  - `LINE_OFFSET_BITS`=4;
  - the line-index extraction function.
- Sub-module `mem_array`:
  - `MEM_LINES`×`MEM_BUS_WIDTH`;
  - one synchronous write port and one combinational read port.
- The FSM, counter and output registers live in `mem_ctrl`.

## Test plan
- Reset then idle: all outputs 0 and `busy`=0 for 10 cycles. Assert `reset` during BUSY_D write of line 3 → no write; a later refill of 0x30 returns 0.
- Write-back then refill, MEM_LATENCY=5:
  - `dc_we`=1, `dc_addr`=0x40, `dc_wdata`=0xDEADBEEF_01234567_89ABCDEF_CAFEF00D → `dc_ack` 5 cycles after accept.
  - Then refill 0x4C → `dc_rdata` equals that pattern.
- Simultaneous `ic_req`/`dc_req` in the same cycle:
  - `dc_ack` first;
  - `ic_ack` at accept+MEM_LATENCY+2+MEM_LATENCY;
  - never both high.
- Address change after accept: refill 0x40 accepted, `ic_addr` changed to 0x80 next cycle → `ic_rdata` is line 4 content.
- Held request: `ic_req` kept high through two acks → exactly MEM_LATENCY+2 edges between pulses. MEM_LATENCY=1 variant: ack in the cycle after accept+1.
- Index wrap with MEM_LINES=1024: write at 0x4000 (line 1024) → a refill at 0x0 returns the same data.
